// File: rtl/xip_read_cache.sv
// APB pass-through with a direct-mapped one-word-per-line read cache for the XIP flash window.
// Flash-window read hits are answered locally; misses, writes and non-flash traffic go downstream.
module xip_read_cache #(
   parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
   parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
   parameter int          ENTRIES    = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [31:0] out_paddr,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   output logic        out_psel,
   output logic        out_penable,
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr,
   input  logic        cache_flush,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_HIT, S_FWD_SETUP, S_FWD_ACCESS, S_RESP} state_t;

   state_t             state, state_nxt;
   logic [ENTRIES-1:0] valid;
   logic [31:0]        data_mem [ENTRIES];
   logic [TAG_W-1:0]   tag_mem  [ENTRIES];

   logic [31:0] req_addr;
   logic [2:0]  req_prot;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        req_cacheable;
   logic [31:0] resp_data;
   logic        resp_err;

   logic [IDX_W-1:0] in_idx, req_idx;
   logic [TAG_W-1:0] in_tag, req_tag;
   logic             in_flash, in_cacheable, tag_match, req_start, dn_done, fill;

   assign in_idx       = in_paddr[2 +: IDX_W];
   assign in_tag       = in_paddr[31 -: TAG_W];
   assign req_idx      = req_addr[2 +: IDX_W];
   assign req_tag      = req_addr[31 -: TAG_W];
   assign in_flash     = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
   assign in_cacheable = in_flash && !in_pwrite;
   assign tag_match    = valid[in_idx] && (tag_mem[in_idx] == in_tag);
   assign req_start    = (state == S_IDLE) && in_psel && in_penable;
   assign dn_done      = (state == S_FWD_ACCESS) && out_pready;
   assign fill         = dn_done && req_cacheable && !out_pslverr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         valid      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         // Flush overrides both a same-cycle fill and a write invalidation.
         if (cache_flush) begin
            valid <= '0;
         end else begin
            if (req_start && in_flash && in_pwrite && tag_match)
               valid[in_idx] <= 1'b0;
            if (fill)
               valid[req_idx] <= 1'b1;
         end
         if (state == S_HIT)
            hit_count <= hit_count + 32'd1;
         if (dn_done && req_cacheable)
            miss_count <= miss_count + 32'd1;
      end
   end

   // Request capture, line storage and response data carry no reset; validity is tracked above.
   always_ff @(posedge clock) begin
      if (req_start) begin
         req_addr      <= in_paddr;
         req_prot      <= in_pprot;
         req_write     <= in_pwrite;
         req_wdata     <= in_pwdata;
         req_strb      <= in_pstrb;
         req_cacheable <= in_cacheable;
         resp_data     <= data_mem[in_idx];
         resp_err      <= 1'b0;
      end
      if (fill) begin
         data_mem[req_idx] <= out_prdata;
         tag_mem[req_idx]  <= req_tag;
      end
      if (dn_done) begin
         resp_data <= out_prdata;
         resp_err  <= out_pslverr;
      end
   end

   always_comb begin
      state_nxt   = state;
      in_pready   = 1'b0;
      in_pslverr  = 1'b0;
      out_psel    = 1'b0;
      out_penable = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_start)
               state_nxt = (in_cacheable && tag_match) ? S_HIT : S_FWD_SETUP;
         end
         S_HIT: begin
            in_pready = 1'b1;
            state_nxt = S_IDLE;
         end
         S_FWD_SETUP: begin
            out_psel  = 1'b1;
            state_nxt = S_FWD_ACCESS;
         end
         S_FWD_ACCESS: begin
            out_psel    = 1'b1;
            out_penable = 1'b1;
            if (out_pready)
               state_nxt = S_RESP;
         end
         S_RESP: begin
            in_pready  = 1'b1;
            in_pslverr = resp_err;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_prdata  = in_pready ? resp_data : '0;
   assign out_paddr  = out_psel ? req_addr  : '0;
   assign out_pprot  = out_psel ? req_prot  : '0;
   assign out_pwrite = out_psel ? req_write : 1'b0;
   assign out_pwdata = out_psel ? req_wdata : '0;
   assign out_pstrb  = out_psel ? req_strb  : '0;

endmodule

// File: tb/tb_xip_read_cache.sv
// Directed bench for xip_read_cache: table of upstream transfers with a downstream APB responder,
// plus hand-written flush-during-fill and reset-during-access sequences.
module tb_xip_read_cache;

   logic        clock, reset;
   logic [31:0] in_paddr, in_pwdata, in_prdata;
   logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
   logic [2:0]  in_pprot, out_pprot;
   logic [3:0]  in_pstrb, out_pstrb;
   logic [31:0] out_paddr, out_pwdata, out_prdata;
   logic        out_pwrite, out_psel, out_penable, out_pready, out_pslverr;
   logic        cache_flush;
   logic [31:0] hit_count, miss_count;

   xip_read_cache dut (
      .clock(clock), .reset(reset),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
      .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
      .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
      .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwrite(out_pwrite),
      .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_psel(out_psel),
      .out_penable(out_penable), .out_pready(out_pready), .out_prdata(out_prdata),
      .out_pslverr(out_pslverr), .cache_flush(cache_flush),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] dn_data;
      logic        dn_err;
      int          dn_wait;
      logic        fwd;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] hits;
      logic [31:0] misses;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   logic [31:0] r_rdata, cap_addr, cap_wdata;
   logic        r_err, r_timeout, cap_write;
   logic [2:0]  cap_prot;
   logic [3:0]  cap_strb;
   int          r_lat, r_setups, r_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Upstream APB master plus downstream responder, one loop iteration per clock.
   task automatic xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] dn_data, input logic dn_err,
                       input int dn_wait, input logic flush_on_ready);
      int cyc;
      logic done;
      r_rdata = '0; r_err = 1'b0; r_lat = 0; r_setups = 0; r_acc = 0; r_timeout = 1'b0;
      cap_addr = '0; cap_wdata = '0; cap_write = 1'b0; cap_prot = '0; cap_strb = '0;
      @(negedge clock);
      in_paddr = addr; in_pwrite = write; in_pwdata = wdata; in_pstrb = strb;
      in_pprot = 3'b101; in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 100) begin
         @(posedge clock);
         #1;
         cyc++;
         cache_flush = 1'b0;
         if (in_pready) begin
            r_rdata = in_prdata; r_err = in_pslverr; r_lat = cyc; done = 1'b1;
         end
         if (out_psel && !out_penable) begin
            r_setups++;
            cap_addr = out_paddr; cap_wdata = out_pwdata; cap_write = out_pwrite;
            cap_prot = out_pprot; cap_strb = out_pstrb;
         end
         if (out_psel && out_penable) begin
            r_acc++;
            if (r_acc > dn_wait) begin
               out_pready = 1'b1; out_prdata = dn_data; out_pslverr = dn_err;
               cache_flush = flush_on_ready;
            end
         end else begin
            out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
         end
      end
      if (!done) r_timeout = 1'b1;
      @(posedge clock);
      #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
      out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0; cache_flush = 1'b0;
   endtask

   task automatic check_xfer(input string nm, input vec_t v);
      chk({nm, "_timeout"}, {31'd0, r_timeout}, 32'd0);
      chk({nm, "_rdata"}, r_rdata, v.rdata);
      chk({nm, "_err"}, {31'd0, r_err}, {31'd0, v.err});
      chk({nm, "_lat"}, r_lat, v.fwd ? v.dn_wait + 3 : 1);
      chk({nm, "_setups"}, r_setups, v.fwd ? 1 : 0);
      chk({nm, "_hits"}, hit_count, v.hits);
      chk({nm, "_misses"}, miss_count, v.misses);
      if (v.fwd) begin
         chk({nm, "_paddr"}, cap_addr, v.addr);
         chk({nm, "_pwrite"}, {31'd0, cap_write}, {31'd0, v.write});
         chk({nm, "_pwdata"}, cap_wdata, v.wdata);
         chk({nm, "_pstrb"}, {28'd0, cap_strb}, {28'd0, v.strb});
         chk({nm, "_pprot"}, {29'd0, cap_prot}, 32'd5);
      end
   endtask

   initial begin
      //            addr          wr    wdata         strb  dn_data       err   wt  fwd   rdata         err   hits    misses
      vecs[0]  = '{32'h3000_0010, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd1};
      vecs[1]  = '{32'h3000_0010, 1'b0, 32'h0,        4'h0, 32'h0,         1'b0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd1, 32'd1};
      vecs[2]  = '{32'h3000_0050, 1'b0, 32'h0,        4'h0, 32'h1111_1111, 1'b0, 0, 1'b1, 32'h1111_1111, 1'b0, 32'd1, 32'd2};
      vecs[3]  = '{32'h3000_0010, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd1, 32'd3};
      vecs[4]  = '{32'h1000_1004, 1'b1, 32'h1234_5678, 4'hA, 32'h0,        1'b0, 2, 1'b1, 32'h0,         1'b0, 32'd1, 32'd3};
      vecs[5]  = '{32'h3000_0020, 1'b0, 32'h0,        4'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd1, 32'd4};
      vecs[6]  = '{32'h3000_0020, 1'b0, 32'h0,        4'h0, 32'h0,         1'b0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'd2, 32'd4};
      vecs[7]  = '{32'h3000_0020, 1'b1, 32'hAAAA_5555, 4'hF, 32'h0,        1'b0, 0, 1'b1, 32'h0,         1'b0, 32'd2, 32'd4};
      vecs[8]  = '{32'h3000_0020, 1'b0, 32'h0,        4'h0, 32'h0BAD_F00D, 1'b0, 0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'd2, 32'd5};
      vecs[9]  = '{32'h3000_0030, 1'b0, 32'h0,        4'h0, 32'h55AA_55AA, 1'b1, 1, 1'b1, 32'h55AA_55AA, 1'b1, 32'd2, 32'd6};
      vecs[10] = '{32'h3000_0030, 1'b0, 32'h0,        4'h0, 32'h1212_1212, 1'b0, 0, 1'b1, 32'h1212_1212, 1'b0, 32'd2, 32'd7};
      vecs[11] = '{32'h2000_0000, 1'b0, 32'h0,        4'h0, 32'h8765_4321, 1'b0, 0, 1'b1, 32'h8765_4321, 1'b0, 32'd2, 32'd7};
      vecs[12] = '{32'h3000_0030, 1'b0, 32'h0,        4'h0, 32'h0,         1'b0, 0, 1'b0, 32'h1212_1212, 1'b0, 32'd3, 32'd7};
      vecs[13] = '{32'h3FFF_FFFC, 1'b0, 32'h0,        4'h0, 32'h3F3F_3F3F, 1'b0, 0, 1'b1, 32'h3F3F_3F3F, 1'b0, 32'd3, 32'd8};
      vecs[14] = '{32'h3FFF_FFFC, 1'b0, 32'h0,        4'h0, 32'h0,         1'b0, 0, 1'b0, 32'h3F3F_3F3F, 1'b0, 32'd4, 32'd8};
      vecs[15] = '{32'h4000_0000, 1'b0, 32'h0,        4'h0, 32'h4444_0000, 1'b0, 0, 1'b1, 32'h4444_0000, 1'b0, 32'd4, 32'd8};
      vecs[16] = '{32'h4000_0000, 1'b0, 32'h0,        4'h0, 32'h4444_0001, 1'b0, 1, 1'b1, 32'h4444_0001, 1'b0, 32'd4, 32'd8};
      vecs[17] = '{32'h3FFF_FFFE, 1'b0, 32'h0,        4'h0, 32'h0,         1'b0, 0, 1'b0, 32'h3F3F_3F3F, 1'b0, 32'd5, 32'd8};
      vecs[18] = '{32'h2FFF_FFFC, 1'b0, 32'h0,        4'h0, 32'h2F2F_2F2F, 1'b0, 0, 1'b1, 32'h2F2F_2F2F, 1'b0, 32'd5, 32'd8};

      reset = 1'b1; cache_flush = 1'b0;
      in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = '0; in_pwrite = 1'b0;
      in_pwdata = '0; in_pstrb = '0; out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_pready", {31'd0, in_pready}, 32'd0);
      chk("rst_in_prdata", in_prdata, 32'd0);
      chk("rst_in_pslverr", {31'd0, in_pslverr}, 32'd0);
      chk("rst_out_psel", {30'd0, out_psel, out_penable}, 32'd0);
      chk("rst_out_paddr", out_paddr, 32'd0);
      chk("rst_out_pwdata", out_pwdata, 32'd0);
      chk("rst_out_misc", {24'd0, out_pprot, out_pwrite, out_pstrb}, 32'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         xfer(vecs[i].addr, vecs[i].write, vecs[i].wdata, vecs[i].strb,
              vecs[i].dn_data, vecs[i].dn_err, vecs[i].dn_wait, 1'b0);
         check_xfer($sformatf("v%0d", i), vecs[i]);
      end

      // Flush on the out_pready cycle of a fill: the data still returns but the line stays invalid.
      xfer(32'h3000_0040, 1'b0, '0, '0, 32'h4040_4040, 1'b0, 2, 1'b1);
      chk("flush_fill_rdata", r_rdata, 32'h4040_4040);
      chk("flush_fill_misses", miss_count, 32'd9);
      xfer(32'h3000_0040, 1'b0, '0, '0, 32'h4141_4141, 1'b0, 0, 1'b0);
      chk("flush_reread_setups", r_setups, 32'd1);
      chk("flush_reread_rdata", r_rdata, 32'h4141_4141);
      chk("flush_reread_misses", miss_count, 32'd10);
      xfer(32'h3FFF_FFFC, 1'b0, '0, '0, 32'h5050_5050, 1'b0, 0, 1'b0);
      chk("flush_other_setups", r_setups, 32'd1);
      chk("flush_other_counts", {hit_count[15:0], miss_count[15:0]}, {16'd5, 16'd11});

      // Reset while the downstream access phase is stalled.
      @(negedge clock);
      in_paddr = 32'h3000_0044; in_pwrite = 1'b0; in_pprot = 3'b101; in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rstmid_pre_access", {30'd0, out_psel, out_penable}, 32'd3);
      reset = 1'b1;
      #1;
      chk("rstmid_out_psel", {30'd0, out_psel, out_penable}, 32'd0);
      chk("rstmid_in_pready", {31'd0, in_pready}, 32'd0);
      chk("rstmid_counts", hit_count | miss_count, 32'd0);
      in_psel = 1'b0; in_penable = 1'b0;
      @(posedge clock);
      #1;
      chk("rstmid_next_out_psel", {31'd0, out_psel}, 32'd0);
      chk("rstmid_next_in_pready", {31'd0, in_pready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      xfer(32'h3000_0040, 1'b0, '0, '0, 32'h6060_6060, 1'b0, 0, 1'b0);
      chk("rstmid_reread_setups", r_setups, 32'd1);
      chk("rstmid_reread_rdata", r_rdata, 32'h6060_6060);
      chk("rstmid_reread_counts", {hit_count[15:0], miss_count[15:0]}, {16'd0, 16'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
